osc_counter_monitor: RTL and testbench
======================================

# osc_counter_monitor

OPB-side initiator that drives the oscillator-counter register slave to run a complete frequency self-check. It verifies the bus path through the scratch pad, clears and starts a measurement, waits out the REF_CLK window and reads the count twice. It then range-checks the count and reports the result. It sits between the board health/supervisor logic and the oscillator counter, replacing software polling.

## Interface
Parameters:
- EXP_COUNT, 50000: nominal count (100 MHz / 2 kHz).
- TOL, 500: allowed ± deviation from EXP_COUNT, inclusive.
- WAIT_CYCLES, 150000: OPB_CLK cycles to wait after the start write before the first count read.
- CLR_CYCLES, 8: OPB_CLK cycles to wait after the counter-reset write.
- AUTO_GAP, 1000000: idle cycles between sequences in auto mode.
- SP_PATTERN, 32'h1234A5C3: scratch pad test word.

Ports:
- OPB_CLK in 1: system clock, 100 MHz. One clock only.
- OPB_RST in 1: asynchronous, active-high reset.
- OPB_ADDR out 32: register address; 0 = control, 1 = count, 2 = scratch pad.
- OSC_CT_DI out 32: write data to the slave.
- OSC_CT_DO in 32: read data from the slave.
- OSC_CT_RE out 1: read strobe.
- OSC_CT_WE out 1: write strobe.
- MON_START in 1: single-cycle request to run one sequence.
- MON_AUTO in 1: level; when high, the block repeats sequences continuously.
- MON_BUSY out 1: high while a sequence runs.
- MON_DONE out 1: one-cycle pulse when a sequence ends.
- MON_COUNT out 16: last count read.
- MON_FREQ_OK out 1: last sequence passed.
- MON_BUS_ERR out 1: scratch pad readback mismatch.
- MON_UNSTABLE out 1: the two count reads differed.

## Operation
- FSM states: IDLE, SP_WR, SP_RD, SP_CHK, CLR_WR, CLR_WAIT, ST_WR, MEAS_WAIT, RD1, RD1_CAP, RD2, RD2_CAP, CHECK, DONE, GAP.
- IDLE: go to SP_WR when MON_START=1, or when MON_AUTO=1.
- SP_WR: write SP_PATTERN to address 2.
- SP_RD: read address 2.
- SP_CHK: the slave returns only the low 16 bits, so compare against {16'h0, SP_PATTERN[15:0]}.
  - On mismatch: MON_BUS_ERR=1, MON_FREQ_OK=0, go to DONE. No measurement runs.
- CLR_WR: write 32'h2 to address 0 (counter reset).
- CLR_WAIT: wait CLR_CYCLES.
- ST_WR: write 32'h1 to address 0 (start).
- MEAS_WAIT: down-counter loaded with WAIT_CYCLES-1. Counter width is clog2(max(WAIT_CYCLES, AUTO_GAP)).
- RD1/RD1_CAP and RD2/RD2_CAP: read address 1 twice and capture both results.
- CHECK:
  - MON_COUNT takes the second read.
  - MON_UNSTABLE = (read1 != read2).
  - MON_FREQ_OK = ~unstable && count >= LO && count <= HI.
  - LO = max(EXP_COUNT-TOL, 1). A count of 0 always fails (dead REF_CLK).
  - HI = min(EXP_COUNT+TOL, 65535).
  - Compute the bounds in 18-bit signed arithmetic; no wrap-around is allowed.
- DONE: pulse MON_DONE. Go to GAP if MON_AUTO=1, else IDLE.
- GAP: wait AUTO_GAP cycles, then go to SP_WR if MON_AUTO=1, else IDLE.
- MON_START while MON_BUSY=1 is ignored and not queued.
- Clearing MON_AUTO mid-sequence lets the current sequence complete.
- Status outputs update only in SP_CHK (bus error) and CHECK. They hold their values until the next CHECK or bus error.
- A new sequence clears MON_BUS_ERR and MON_UNSTABLE on entry to SP_WR.

## Timing
- Reset values:
  - OPB_ADDR=0, OSC_CT_DI=0, OSC_CT_RE=0, OSC_CT_WE=0.
  - MON_BUSY=0, MON_DONE=0, MON_COUNT=0, MON_FREQ_OK=0, MON_BUS_ERR=0, MON_UNSTABLE=0.
  - FSM=IDLE.
- All outputs are registered.
- RE and WE are single-cycle pulses, never asserted together, with at least one idle cycle between strobes.
- OPB_ADDR and OSC_CT_DI are valid in the same cycle as the strobe and hold their values afterwards.
- Read latency:
  - RE is high in cycle T.
  - The slave registers DO at the end of T.
  - The block captures OSC_CT_DO at the end of T+1 (the *_CAP states).
- MON_BUSY rises the cycle after the MON_START sample and falls in the same cycle MON_DONE pulses.
- Nominal sequence length is about 20 + CLR_CYCLES + WAIT_CYCLES cycles.
- OPB_RST mid-sequence: immediate return to the reset values, with no strobe completed. The slave shares OPB_RST, so no cleanup transaction is needed.

## Test plan
- Slave model returns SP ok and count 50000 on both reads, MON_START pulse:
  - bus sequence is W2=1234A5C3, R2, W0=2, W0=1, R1, R1;
  - then MON_DONE with MON_FREQ_OK=1 and MON_COUNT=50000.
- Count 50501 -> MON_FREQ_OK=0, MON_COUNT=50501. Count 49500 -> MON_FREQ_OK=1 (boundary is inclusive).
- Count 0 (REF_CLK stopped) -> MON_FREQ_OK=0, MON_UNSTABLE=0.
- Reads return 49990 then 50000 -> MON_UNSTABLE=1, MON_FREQ_OK=0.
- SP readback 0000FFFF -> MON_BUS_ERR=1, no writes to address 0 occur, MON_DONE pulses.
- MON_START during MEAS_WAIT is ignored; OPB_RST during MEAS_WAIT gives all outputs 0 and FSM IDLE.
- MON_AUTO=1 -> sequences repeat with AUTO_GAP idle cycles between them.

Source files
------------

// File: rtl/osc_counter_monitor.sv
// OPB initiator that runs an oscillator-counter self-check: scratch pad loopback,
// counter clear/start, timed wait, double count read and range check.
module osc_counter_monitor #(
   parameter int unsigned EXP_COUNT   = 50000,
   parameter int unsigned TOL         = 500,
   parameter int unsigned WAIT_CYCLES = 150000,
   parameter int unsigned CLR_CYCLES  = 8,
   parameter int unsigned AUTO_GAP    = 1000000,
   parameter logic [31:0] SP_PATTERN  = 32'h1234A5C3
) (
   input  logic        OPB_CLK,
   input  logic        OPB_RST,
   output logic [31:0] OPB_ADDR,
   output logic [31:0] OSC_CT_DI,
   input  logic [31:0] OSC_CT_DO,
   output logic        OSC_CT_RE,
   output logic        OSC_CT_WE,
   input  logic        MON_START,
   input  logic        MON_AUTO,
   output logic        MON_BUSY,
   output logic        MON_DONE,
   output logic [15:0] MON_COUNT,
   output logic        MON_FREQ_OK,
   output logic        MON_BUS_ERR,
   output logic        MON_UNSTABLE
);

   localparam int unsigned MAX_A   = (WAIT_CYCLES > AUTO_GAP) ? WAIT_CYCLES : AUTO_GAP;
   localparam int unsigned MAX_CNT = (MAX_A > CLR_CYCLES) ? MAX_A : CLR_CYCLES;
   localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic signed [17:0] EXP_S  = 18'(EXP_COUNT);
   localparam logic signed [17:0] TOL_S  = 18'(TOL);
   localparam logic signed [17:0] LO_RAW = EXP_S - TOL_S;
   localparam logic signed [17:0] HI_RAW = EXP_S + TOL_S;
   // A zero count means REF_CLK is dead, so the low bound never drops below 1.
   localparam logic signed [17:0] LO_BOUND = (LO_RAW < 18'sd1) ? 18'sd1 : LO_RAW;
   localparam logic signed [17:0] HI_BOUND = (HI_RAW > 18'sd65535) ? 18'sd65535 : HI_RAW;

   localparam logic [31:0] ADDR_CTRL  = 32'd0;
   localparam logic [31:0] ADDR_COUNT = 32'd1;
   localparam logic [31:0] ADDR_SP    = 32'd2;

   typedef enum logic [3:0] {
      IDLE, SP_WR, SP_RD, SP_CHK, CLR_WR, CLR_WAIT, ST_WR, MEAS_WAIT,
      RD1, RD1_CAP, RD2, RD2_CAP, CHECK, DONE, GAP
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    di_q, di_d;
   logic           re_q, re_d;
   logic           we_q, we_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [15:0]    count_q, count_d;
   logic           freq_ok_q, freq_ok_d;
   logic           bus_err_q, bus_err_d;
   logic           unstable_q, unstable_d;
   logic [15:0]    rd1_q, rd1_d;
   logic [15:0]    rd2_q, rd2_d;
   logic           start_seq;
   logic signed [17:0] rd2_s;

   assign rd2_s = signed'({2'b00, rd2_q});

   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      di_d       = di_q;
      re_d       = 1'b0;
      we_d       = 1'b0;
      count_d    = count_q;
      freq_ok_d  = freq_ok_q;
      bus_err_d  = bus_err_q;
      unstable_d = unstable_q;
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      start_seq  = 1'b0;

      // Strobes are registered, so each is raised on the transition into its state.
      case (state_q)
         IDLE:      if (MON_START || MON_AUTO) start_seq = 1'b1;
         SP_WR: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = SP_RD;
               re_d    = 1'b1;
               addr_d  = ADDR_SP;
            end
         end
         SP_RD:     state_d = SP_CHK;
         SP_CHK: begin
            if (OSC_CT_DO != {16'h0, SP_PATTERN[15:0]}) begin
               bus_err_d = 1'b1;
               freq_ok_d = 1'b0;
               state_d   = DONE;
            end else begin
               state_d = CLR_WR;
               we_d    = 1'b1;
               addr_d  = ADDR_CTRL;
               di_d    = 32'h2;
            end
         end
         CLR_WR: begin
            state_d = CLR_WAIT;
            cnt_d   = CW'(CLR_CYCLES - 1);
         end
         CLR_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = ST_WR;
               we_d    = 1'b1;
               addr_d  = ADDR_CTRL;
               di_d    = 32'h1;
            end
         end
         ST_WR: begin
            state_d = MEAS_WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
         end
         MEAS_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = RD1;
               re_d    = 1'b1;
               addr_d  = ADDR_COUNT;
            end
         end
         RD1:       state_d = RD1_CAP;
         RD1_CAP: begin
            rd1_d   = OSC_CT_DO[15:0];
            state_d = RD2;
            re_d    = 1'b1;
            addr_d  = ADDR_COUNT;
         end
         RD2:       state_d = RD2_CAP;
         RD2_CAP: begin
            rd2_d   = OSC_CT_DO[15:0];
            state_d = CHECK;
         end
         CHECK: begin
            count_d    = rd2_q;
            unstable_d = (rd1_q != rd2_q);
            freq_ok_d  = (rd1_q == rd2_q) && (rd2_s >= LO_BOUND) && (rd2_s <= HI_BOUND);
            state_d    = DONE;
         end
         DONE: begin
            if (MON_AUTO) begin
               state_d = GAP;
               cnt_d   = CW'(AUTO_GAP - 1);
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
            else if (MON_AUTO) start_seq = 1'b1;
            else               state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase

      // The write strobe is followed by one quiet SP_WR cycle before the read.
      if (start_seq) begin
         state_d    = SP_WR;
         cnt_d      = CW'(1);
         we_d       = 1'b1;
         addr_d     = ADDR_SP;
         di_d       = SP_PATTERN;
         bus_err_d  = 1'b0;
         unstable_d = 1'b0;
      end

      busy_d = !(state_d inside {IDLE, DONE, GAP});
      done_d = (state_d == DONE);
   end

   // NOTE: state is updated with non-blocking assignments only.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         di_q       <= '0;
         re_q       <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         freq_ok_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         unstable_q <= 1'b0;
         rd1_q      <= '0;
         rd2_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         di_q       <= di_d;
         re_q       <= re_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         freq_ok_q  <= freq_ok_d;
         bus_err_q  <= bus_err_d;
         unstable_q <= unstable_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
      end
   end

   assign OPB_ADDR     = addr_q;
   assign OSC_CT_DI    = di_q;
   assign OSC_CT_RE    = re_q;
   assign OSC_CT_WE    = we_q;
   assign MON_BUSY     = busy_q;
   assign MON_DONE     = done_q;
   assign MON_COUNT    = count_q;
   assign MON_FREQ_OK  = freq_ok_q;
   assign MON_BUS_ERR  = bus_err_q;
   assign MON_UNSTABLE = unstable_q;

endmodule

// File: tb/tb_osc_counter_monitor.sv
// Directed bench for osc_counter_monitor with a registered oscillator-counter slave model
// and a strobe logger; windows are shortened through parameters.
module tb_osc_counter_monitor;

   localparam int WAIT_C = 20;
   localparam int CLR_C  = 4;
   localparam int GAP_C  = 30;
   localparam int LOG_N  = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, di;
   logic [31:0] ct_do = '0;
   logic        re, we;
   logic        start, auto_en;
   logic        busy, done;
   logic [15:0] count;
   logic        freq_ok, bus_err, unstable;

   int checks = 0;
   int errors = 0;

   logic [15:0] cnt1, cnt2;
   bit          sp_bad;

   // strobe monitor state (written only by the negedge monitor)
   logic        re_s = 1'b0, we_s = 1'b0;
   logic [31:0] addr_s = '0, di_s = '0;
   bit          prev_stb = 1'b0;
   int          viol = 0;
   int          n_log = 0;
   int          n_done = 0;
   int          done_cyc = 0;
   int          cyc = 0;
   logic        log_we [LOG_N];
   logic [31:0] log_addr [LOG_N];
   logic [31:0] log_di [LOG_N];
   int          log_cyc [LOG_N];

   // slave state (written only by the posedge slave model)
   logic [31:0] sp_reg = '0;
   bit          rd_idx = 1'b0;

   int log_base, done_base;

   osc_counter_monitor #(
      .EXP_COUNT(50000), .TOL(500), .WAIT_CYCLES(WAIT_C), .CLR_CYCLES(CLR_C),
      .AUTO_GAP(GAP_C), .SP_PATTERN(32'h1234A5C3)
   ) dut (
      .OPB_CLK(clk), .OPB_RST(rst), .OPB_ADDR(addr), .OSC_CT_DI(di), .OSC_CT_DO(ct_do),
      .OSC_CT_RE(re), .OSC_CT_WE(we), .MON_START(start), .MON_AUTO(auto_en),
      .MON_BUSY(busy), .MON_DONE(done), .MON_COUNT(count), .MON_FREQ_OK(freq_ok),
      .MON_BUS_ERR(bus_err), .MON_UNSTABLE(unstable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      re_s   = re;
      we_s   = we;
      addr_s = addr;
      di_s   = di;
      if (rst) begin
         prev_stb = 1'b0;
      end else begin
         if (re && we) viol++;
         if ((re || we) && prev_stb) viol++;
         prev_stb = re || we;
         if (re || we) begin
            if (n_log < LOG_N) begin
               log_we[n_log]   = we;
               log_addr[n_log] = addr;
               log_di[n_log]   = di;
               log_cyc[n_log]  = cyc;
            end
            n_log++;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   // Slave: read data registered at the end of the RE cycle; scratch pad keeps low 16 bits.
   always @(posedge clk) begin
      if (re_s) begin
         if (addr_s == 32'd2)      ct_do <= sp_bad ? 32'h0000FFFF : {16'h0, sp_reg[15:0]};
         else if (addr_s == 32'd1) begin
            ct_do  <= {16'h0, rd_idx ? cnt2 : cnt1};
            rd_idx <= ~rd_idx;
         end else                  ct_do <= '0;
      end
      if (we_s) begin
         if (addr_s == 32'd2) sp_reg <= di_s;
         if (addr_s == 32'd0 && di_s == 32'h2) rd_idx <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int target, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (n_done - done_base >= target) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_status(input string nm, input logic [15:0] c,
                               input logic ok, input logic be, input logic un);
      check({nm, "_count"}, count, c);
      check({nm, "_ok"}, freq_ok, ok);
      check({nm, "_buserr"}, bus_err, be);
      check({nm, "_unstable"}, unstable, un);
   endtask

   task automatic pulse_start(input string nm);
      @(negedge clk);
      check({nm, "_idle_busy"}, busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 check({nm, "_busy_rise"}, busy, 1);
   endtask

   task automatic run_seq(input string nm, input logic [15:0] c1, input logic [15:0] c2,
                          input bit bad);
      bit seen;
      cnt1 = c1; cnt2 = c2; sp_bad = bad;
      log_base = n_log; done_base = n_done;
      pulse_start(nm);
      wait_done(1, seen);
      check({nm, "_done"}, seen, 1);
      check({nm, "_done_busy"}, {done, busy}, 2'b10);
   endtask

   function automatic logic [31:0] exp_op(input int k);
      case (k)
         0: return 32'h8000_0002;
         1: return 32'h0000_0002;
         2: return 32'h8000_0000;
         3: return 32'h8000_0000;
         default: return 32'h0000_0001;
      endcase
   endfunction

   function automatic logic [31:0] exp_di(input int k);
      case (k)
         0, 1: return 32'h1234A5C3;
         2: return 32'h2;
         default: return 32'h1;
      endcase
   endfunction

   initial begin
      bit seen;
      int idx, nw0, d1;
      rst = 1'b1; start = 1'b0; auto_en = 1'b0;
      cnt1 = 16'd0; cnt2 = 16'd0; sp_bad = 1'b0;
      log_base = 0; done_base = 0;
      repeat (2) @(negedge clk);
      check("rst_addr", addr, 0);
      check("rst_di", di, 0);
      check("rst_count", count, 0);
      check("rst_flags", {re, we, busy, done, freq_ok, bus_err, unstable}, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // nominal run, full bus trace and wait windows
      run_seq("nom", 16'd50000, 16'd50000, 1'b0);
      check_status("nom", 16'd50000, 1, 0, 0);
      check("nom_nlog", n_log - log_base, 6);
      for (int k = 0; k < 6; k++) begin
         idx = log_base + k;
         check($sformatf("bus%0d_op", k), {log_we[idx], log_addr[idx][30:0]}, exp_op(k));
         check($sformatf("bus%0d_di", k), log_di[idx], exp_di(k));
      end
      check("clr_wait", log_cyc[log_base+3] - log_cyc[log_base+2], CLR_C + 1);
      check("meas_wait", log_cyc[log_base+4] - log_cyc[log_base+3], WAIT_C + 1);
      check("rd_spacing", log_cyc[log_base+5] - log_cyc[log_base+4], 2);

      run_seq("hi_out", 16'd50501, 16'd50501, 1'b0);
      check_status("hi_out", 16'd50501, 0, 0, 0);
      run_seq("lo_edge", 16'd49500, 16'd49500, 1'b0);
      check_status("lo_edge", 16'd49500, 1, 0, 0);
      run_seq("hi_edge", 16'd50500, 16'd50500, 1'b0);
      check_status("hi_edge", 16'd50500, 1, 0, 0);
      run_seq("lo_out", 16'd49499, 16'd49499, 1'b0);
      check_status("lo_out", 16'd49499, 0, 0, 0);
      run_seq("dead", 16'd0, 16'd0, 1'b0);
      check_status("dead", 16'd0, 0, 0, 0);
      run_seq("unstab", 16'd49990, 16'd50000, 1'b0);
      check_status("unstab", 16'd50000, 0, 0, 1);

      // scratch pad failure: count holds, unstable cleared, no control writes
      run_seq("buserr", 16'd50000, 16'd50000, 1'b1);
      check_status("buserr", 16'd50000, 0, 1, 0);
      check("buserr_nlog", n_log - log_base, 2);
      nw0 = 0;
      for (int k = log_base; k < n_log; k++)
         if (log_we[k] && log_addr[k] == 32'd0) nw0++;
      check("buserr_w0", nw0, 0);

      run_seq("recover", 16'd50000, 16'd50000, 1'b0);
      check_status("recover", 16'd50000, 1, 0, 0);

      // MON_START inside MEAS_WAIT is dropped
      cnt1 = 16'd50000; cnt2 = 16'd50000; sp_bad = 1'b0;
      log_base = n_log; done_base = n_done;
      pulse_start("ign");
      repeat (13) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, seen);
      check("ign_done", seen, 1);
      repeat (40) @(negedge clk);
      check("ign_nlog", n_log - log_base, 6);
      check("ign_ndone", n_done - done_base, 1);
      check("ign_busy", busy, 0);

      // reset in MEAS_WAIT
      log_base = n_log; done_base = n_done;
      pulse_start("mrst");
      repeat (13) @(negedge clk);
      check("mrst_inmeas", n_log - log_base, 4);
      rst = 1'b1;
      #1;
      check("mrst_addr", addr, 0);
      check("mrst_di", di, 0);
      check("mrst_count", count, 0);
      check("mrst_flags", {re, we, busy, done, freq_ok, bus_err, unstable}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("mrst_idle_nlog", n_log - log_base, 4);
      check("mrst_idle", {busy, n_done - done_base}, 0);

      // auto mode: gap between sequences, then clear mid-sequence
      log_base = n_log; done_base = n_done;
      @(negedge clk);
      auto_en = 1'b1;
      wait_done(1, seen);
      check("auto_done1", seen, 1);
      check_status("auto1", 16'd50000, 1, 0, 0);
      d1 = done_cyc;
      repeat (5) @(negedge clk);
      check("auto_gap_busy", busy, 0);
      check("auto_gap_quiet", n_log - log_base, 6);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (n_log - log_base >= 7) begin
            seen = 1'b1;
            break;
         end
      end
      check("auto_restart", seen, 1);
      idx = log_base + 6;
      check("auto_op", {log_we[idx], log_addr[idx][30:0]}, 32'h8000_0002);
      check("auto_gap_len", log_cyc[idx] - d1, GAP_C + 1);
      auto_en = 1'b0;
      wait_done(2, seen);
      check("auto_done2", seen, 1);
      repeat (60) @(negedge clk);
      check("auto_stop_nlog", n_log - log_base, 12);
      check("auto_stop_ndone", n_done - done_base, 2);

      check("protocol", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
